// File: rtl/enigma_led_driver.sv
// Status-LED driver: NUM_LEDS channels, each off/level/pulse-stretch/blink,
// gated by a shared PWM brightness and driven with selectable pin polarity.
module enigma_led_driver #(
   parameter int NUM_LEDS      = 5,
   parameter int CLK_HZ        = 100000000,
   parameter int TICK_HZ       = 1000,
   parameter int STRETCH_TICKS = 50,
   parameter int BLINK_TICKS   = 250,
   parameter int PWM_BITS      = 4,
   parameter bit ACTIVE_HIGH   = 1'b1
) (
   input  logic                    clk_100mhz,
   input  logic                    ext_rst_n,
   input  logic [2*NUM_LEDS-1:0]   led_mode,
   input  logic [NUM_LEDS-1:0]     led_in,
   input  logic [PWM_BITS-1:0]     brightness,
   output logic [NUM_LEDS-1:0]     led_out,
   output logic                    tick_out
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PRE_W    = $clog2(TICK_DIV + 1);
   localparam int STR_W    = $clog2(STRETCH_TICKS + 1);
   localparam int BLK_W    = $clog2(BLINK_TICKS + 1);

   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_PENULT = PRE_W'(TICK_DIV - 2);
   localparam logic [STR_W-1:0] STR_LOAD   = STR_W'(STRETCH_TICKS);
   localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_TICKS - 1);

   localparam logic [1:0] MODE_OFF     = 2'b00;
   localparam logic [1:0] MODE_LEVEL   = 2'b01;
   localparam logic [1:0] MODE_STRETCH = 2'b10;
   localparam logic [1:0] MODE_BLINK   = 2'b11;

   localparam logic [NUM_LEDS-1:0] INACTIVE = ACTIVE_HIGH ? '0 : '1;

   logic [PRE_W-1:0]    presc;
   logic [BLK_W-1:0]    blink_cnt;
   logic                phase;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [NUM_LEDS-1:0] in_q;
   logic [NUM_LEDS-1:0] in_qq;
   logic [STR_W-1:0]    str_cnt [NUM_LEDS];
   logic [NUM_LEDS-1:0] rise;
   logic [NUM_LEDS-1:0] logical;
   logic                gate;

   assign rise = in_q & ~in_qq;
   assign gate = (&brightness) | (pwm_cnt < brightness);

   always_comb begin
      logical = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         case (led_mode[2*i +: 2])
            MODE_OFF:     logical[i] = 1'b0;
            MODE_LEVEL:   logical[i] = in_q[i];
            MODE_STRETCH: logical[i] = (str_cnt[i] != '0);
            MODE_BLINK:   logical[i] = in_q[i] & phase;
            default:      logical[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (!ext_rst_n) begin
         presc     <= '0;
         tick_out  <= 1'b0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         pwm_cnt   <= '0;
         in_q      <= '0;
         in_qq     <= '0;
         led_out   <= INACTIVE;
         for (int i = 0; i < NUM_LEDS; i++) begin
            str_cnt[i] <= '0;
         end
      end else begin
         presc    <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
         // registered one count early so tick_out is high exactly while presc == TICK_DIV-1
         tick_out <= (presc == PRE_PENULT);
         in_q     <= led_in;
         in_qq    <= in_q;
         pwm_cnt  <= pwm_cnt + 1'b1;

         if (tick_out) begin
            if (blink_cnt == BLK_LAST) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end

         // a rising edge reloads even on a tick cycle, so retriggers extend the pulse
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (led_mode[2*i +: 2] != MODE_STRETCH) begin
               str_cnt[i] <= '0;
            end else if (rise[i]) begin
               str_cnt[i] <= STR_LOAD;
            end else if (tick_out && (str_cnt[i] != '0)) begin
               str_cnt[i] <= str_cnt[i] - 1'b1;
            end
         end

         led_out <= (logical & {NUM_LEDS{gate}}) ^ INACTIVE;
      end
   end

endmodule

// File: doc/enigma_led_driver.md
Name: enigma_led_driver

Overview:
- Parametrised status-LED driver for the Enigma board tops. Replaces hardwired per-LED assigns with NUM_LEDS independent channels.
- Each channel has a selectable mode: off, level, pulse-stretch or blink. A global PWM brightness gate and selectable output polarity let one block serve every board variant.
- Sits between the core status signals and the led_* pins of the board-level top.

Parameters:
- NUM_LEDS, 5, number of channels (1..32).
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 1000, timebase tick rate. TICK_DIV = CLK_HZ/TICK_HZ (integer, floor, >=2).
- STRETCH_TICKS, 50, pulse-stretch length in ticks (>=1).
- BLINK_TICKS, 250, blink half-period in ticks (>=1).
- PWM_BITS, 4, brightness resolution.
- ACTIVE_HIGH, 1, 1: LED lit when pin high; 0: pins inverted.

Ports:
- clk_100mhz  in  1  system clock.
- ext_rst_n  in  1  reset. Synchronous, active-low.
- led_mode  in  2*NUM_LEDS  per-channel mode; bits [2i+1:2i] belong to channel i. 00 off, 01 level, 10 stretch, 11 blink.
- led_in  in  NUM_LEDS  per-channel status input (level or event source).
- brightness  in  PWM_BITS  global duty. 0 = dark, all-ones = 100%.
- led_out  out  NUM_LEDS  registered pin drive, polarity per ACTIVE_HIGH.
- tick_out  out  1  one-cycle timebase pulse, for reuse by neighbours.

Behaviour:
- Reset (ext_rst_n=0 at a clock edge):
  - prescaler, stretch counters, blink counter, PWM counter, input registers and blink phase go to 0.
  - tick_out goes to 0.
  - led_out goes to the inactive level: all 0 if ACTIVE_HIGH, else all 1.
  - Reset asserted mid-stretch or mid-blink aborts the operation on the next edge, with no residual pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps.
  - tick_out=1 for exactly the cycle in which the count equals TICK_DIV-1.
  - The first tick is TICK_DIV cycles after reset release.
- Input register: led_in is registered once (in_q); the previous value is held in in_qq for edge detection.
- Mode 00 (off): logical state 0. The channel's stretch counter is held at 0.
- Mode 01 (level): logical state = in_q.
- Mode 10 (stretch):
  - Rising edge (in_q & ~in_qq) loads that channel's counter with STRETCH_TICKS.
  - Otherwise the counter decrements by 1 on each tick while nonzero, saturating at 0.
  - Logical state = (counter != 0).
  - Edge and tick in the same cycle: the load wins (retrigger extends the pulse).
  - Leaving mode 10 clears the counter.
- Mode 11 (blink):
  - One shared blink counter counts ticks 0..BLINK_TICKS-1; at wrap, the shared phase toggles.
  - Logical state = in_q & phase. All blinking channels stay in sync.
  - in_q low gives a dark channel immediately (counter keeps running).
- PWM:
  - Free-running PWM_BITS counter increments every clock.
  - gate = 1 if brightness is all-ones, else (pwm_cnt < brightness).
  - brightness=0 means led_out stays at the inactive level.
  - brightness is sampled every cycle, with no glitch protection required.
- Output: led_out[i] = register of (logical[i] & gate), inverted when ACTIVE_HIGH=0.
- Latency:
  - led_in to led_out in level mode, brightness all-ones: 2 cycles.
  - Mode change to led_out: 1 cycle.
- Widths: counters are sized with $clog2(param+1). No overflow is possible at legal parameters.

Test Plan:
1. NUM_LEDS=5, CLK_HZ=100, TICK_HZ=10, STRETCH_TICKS=3, BLINK_TICKS=2, brightness=F, ACTIVE_HIGH=1.
   - Hold reset 3 cycles -> led_out=00000, tick_out=0.
   - After release, tick_out pulses at cycles 10, 20, 30 and is 1 cycle wide.
2. Ch0 mode 01, led_in[0] rises at cycle N -> led_out[0]=1 at N+2; falls at M -> 0 at M+2.
3. Ch1 mode 10, single 1-cycle pulse on led_in[1] -> led_out[1] high for 3 ticks (about 30 cycles), then low.
   - Second pulse coinciding with a tick after 2 ticks -> pulse extends to a fresh 3 ticks.
4. Ch2 and ch3 mode 11, led_in high -> both outputs toggle every 20 cycles, in phase.
   - Drop led_in[2] -> ch2 dark within 2 cycles; ch3 unaffected.
5. brightness=4, ch0 level high -> led_out[0] high 4 of every 16 cycles.
   - brightness=0 -> constant 0.
   - Rerun test 2 with ACTIVE_HIGH=0 -> outputs inverted, reset value 11111.
6. Assert reset mid-stretch on ch1 -> led_out[1]=0 on the next edge.
   - After release, the counter restarts only on a new rising edge.
